pwm_duty_ramp_ctrl: RTL and testbench

//   Sequences duty updates for a left/right pair of 11-bit PWM generators (motor drive).

---
 rtl/pwm_duty_ramp_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty sequencer for a left/right PWM11 pair: slews each wheel's duty magnitude once per
// PWM period and inserts a ramp-to-zero plus dead-hold on every direction reversal.
module pwm_duty_ramp_ctrl #(
  parameter int unsigned PERIOD   = 2048,
  parameter int unsigned STEP     = 16,
  parameter int unsigned REV_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tgt_vld,
  input  logic [11:0] tgt_lft,
  input  logic [11:0] tgt_rght,
  output logic        tgt_rdy,
  output logic [10:0] lft_duty,
  output logic        lft_fwd,
  output logic [10:0] rght_duty,
  output logic        rght_fwd,
  output logic        period_strb,
  output logic        settled
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned HW = $clog2(REV_HOLD + 1);
  localparam int unsigned DW = 11;
  localparam logic [DW:0] STEP_W = (DW+1)'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, DECEL, HOLD} state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strb_d;
  logic          rdy_d, settled_d, cap;

  // Index 0 = left channel, 1 = right channel.
  state_t        state_q [2];
  state_t        state_d [2];
  logic [DW-1:0] duty_q  [2];
  logic [DW-1:0] duty_d  [2];
  logic          fwd_q   [2];
  logic          fwd_d   [2];
  logic [HW-1:0] hold_q  [2];
  logic [HW-1:0] hold_d  [2];
  logic [DW-1:0] mag_q   [2];
  logic [DW-1:0] mag_d   [2];
  logic          dir_q   [2];
  logic          dir_d   [2];
  logic [DW-1:0] dec     [2];

  // |t| clipped to 2047, so -2048 maps to full scale rather than wrapping.
  function automatic logic [DW-1:0] tgt_mag(input logic [11:0] t);
    logic [11:0] a;
    a = t[11] ? 12'(~t + 12'd1) : t;
    return (a > 12'd2047) ? 11'd2047 : a[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] ramp(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic [DW:0] c, m;
    c = {1'b0, cur};
    m = {1'b0, tgt};
    if (c > m) return ((c - m) <= STEP_W) ? tgt : DW'(c - STEP_W);
    else       return ((m - c) <= STEP_W) ? tgt : DW'(c + STEP_W);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      period_strb <= 1'b0;
      tgt_rdy     <= 1'b1;
      settled     <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        duty_q[i]  <= '0;
        fwd_q[i]   <= 1'b1;
        hold_q[i]  <= '0;
        mag_q[i]   <= '0;
        dir_q[i]   <= 1'b1;
      end
    end else begin
      cnt_q       <= cnt_d;
      period_strb <= strb_d;
      tgt_rdy     <= rdy_d;
      settled     <= settled_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        fwd_q[i]   <= fwd_d[i];
        hold_q[i]  <= hold_d[i];
        mag_q[i]   <= mag_d[i];
        dir_q[i]   <= dir_d[i];
      end
    end
  end

  always_comb begin
    cnt_d  = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
    // Registered, so it is high exactly while cnt_q == PERIOD-1.
    strb_d = (cnt_q == CW'(PERIOD - 2));
    cap    = tgt_vld & tgt_rdy;

    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      fwd_d[i]   = fwd_q[i];
      hold_d[i]  = hold_q[i];
      mag_d[i]   = mag_q[i];
      dir_d[i]   = dir_q[i];
      dec[i]     = ({1'b0, duty_q[i]} > STEP_W) ? DW'({1'b0, duty_q[i]} - STEP_W) : '0;
    end

    if (cap) begin
      mag_d[0] = tgt_mag(tgt_lft);
      dir_d[0] = ~tgt_lft[11];
      mag_d[1] = tgt_mag(tgt_rght);
      dir_d[1] = ~tgt_rght[11];
    end

    // Channel FSMs step only at the period boundary, on the previously stored target.
    if (period_strb) begin
      for (int i = 0; i < 2; i++) begin
        case (state_q[i])
          IDLE, RAMP: begin
            if (mag_q[i] == '0 || dir_q[i] == fwd_q[i]) begin
              duty_d[i]  = ramp(duty_q[i], mag_q[i]);
              state_d[i] = (duty_d[i] == mag_q[i]) ? IDLE : RAMP;
            end else if (duty_q[i] == '0) begin
              fwd_d[i]   = ~fwd_q[i];
              duty_d[i]  = ramp('0, mag_q[i]);
              state_d[i] = (duty_d[i] == mag_q[i]) ? IDLE : RAMP;
            end else begin
              state_d[i] = DECEL;
            end
          end
          DECEL: begin
            if (mag_q[i] == '0 || dir_q[i] == fwd_q[i]) begin
              duty_d[i]  = ramp(duty_q[i], mag_q[i]);
              state_d[i] = (duty_d[i] == mag_q[i]) ? IDLE : RAMP;
            end else begin
              duty_d[i] = dec[i];
              if (dec[i] == '0) begin
                state_d[i] = HOLD;
                hold_d[i]  = HW'(REV_HOLD);
              end
            end
          end
          HOLD: begin
            duty_d[i] = '0;
            hold_d[i] = hold_q[i] - HW'(1);
            if (hold_d[i] == '0) begin
              fwd_d[i]   = ~fwd_q[i];
              state_d[i] = RAMP;
            end
          end
          default: state_d[i] = IDLE;
        endcase
      end
    end

    rdy_d     = !(state_d[0] == HOLD || state_d[1] == HOLD);
    settled_d = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!(state_d[i] == IDLE && duty_d[i] == mag_d[i] &&
            (fwd_d[i] == dir_d[i] || mag_d[i] == '0)))
        settled_d = 1'b0;
    end
  end

  assign lft_duty  = duty_q[0];
  assign lft_fwd   = fwd_q[0];
  assign rght_duty = duty_q[1];
  assign rght_fwd  = fwd_q[1];

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl: ramps, reversal with hold, abort, clipping, reset.
module tb_pwm_duty_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tgt_vld;
  logic [11:0] tgt_lft;
  logic [11:0] tgt_rght;
  logic        tgt_rdy;
  logic [10:0] lft_duty;
  logic        lft_fwd;
  logic [10:0] rght_duty;
  logic        rght_fwd;
  logic        period_strb;
  logic        settled;

  int checks   = 0;
  int failures = 0;

  pwm_duty_ramp_ctrl dut (
    .clk(clk), .rst(rst), .tgt_vld(tgt_vld), .tgt_lft(tgt_lft), .tgt_rght(tgt_rght),
    .tgt_rdy(tgt_rdy), .lft_duty(lft_duty), .lft_fwd(lft_fwd), .rght_duty(rght_duty),
    .rght_fwd(rght_fwd), .period_strb(period_strb), .settled(settled)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench at a negedge inside the strobe cycle.
  task automatic wait_strobe_high();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strb && n < 2100);
    if (!period_strb) check_val("strobe_timeout", 0, 1);
  endtask

  // Leaves the bench at the negedge just after the FSM update.
  task automatic wait_strobe();
    wait_strobe_high();
    @(negedge clk);
  endtask

  task automatic capture(input int l, input int r);
    tgt_vld  = 1'b1;
    tgt_lft  = 12'(l);
    tgt_rght = 12'(r);
    @(negedge clk);
    tgt_vld  = 1'b0;
  endtask

  task automatic expect_ch(input string tag, input int ld, input int lf, input int rd, input int rf);
    check_val({tag, "_lduty"}, 32'(lft_duty), ld);
    check_val({tag, "_lfwd"},  32'(lft_fwd),  lf);
    check_val({tag, "_rduty"}, 32'(rght_duty), rd);
    check_val({tag, "_rfwd"},  32'(rght_fwd), rf);
  endtask

  initial begin
    int n;
    rst = 1'b1; tgt_vld = 1'b0; tgt_lft = '0; tgt_rght = '0;
    repeat (3) @(negedge clk);
    expect_ch("rst", 0, 1, 0, 1);
    check_val("rst_rdy", 32'(tgt_rdy), 1);
    check_val("rst_strb", 32'(period_strb), 0);
    check_val("rst_settled", 32'(settled), 1);
    rst = 1'b0;

    // Forward ramp; right retargeted to +48 mid-ramp.
    capture(100, 40);
    wait_strobe(); expect_ch("s1", 16, 1, 16, 1);
    check_val("s1_settled", 32'(settled), 0);
    wait_strobe(); expect_ch("s2", 32, 1, 32, 1);
    wait_strobe(); expect_ch("s3", 48, 1, 40, 1);
    capture(100, 48);
    wait_strobe(); expect_ch("s4", 64, 1, 48, 1);
    wait_strobe(); expect_ch("s5", 80, 1, 48, 1);
    wait_strobe(); expect_ch("s6", 96, 1, 48, 1);
    check_val("s6_settled", 32'(settled), 0);
    wait_strobe(); expect_ch("s7", 100, 1, 48, 1);
    check_val("s7_settled", 32'(settled), 1);

    // Right reversal +48 -> -48 through DECEL and HOLD.
    capture(100, -48);
    wait_strobe(); expect_ch("s8", 100, 1, 48, 1);
    check_val("s8_settled", 32'(settled), 0);
    wait_strobe(); expect_ch("s9", 100, 1, 32, 1);
    wait_strobe(); expect_ch("s10", 100, 1, 16, 1);
    check_val("s10_rdy", 32'(tgt_rdy), 1);
    wait_strobe(); expect_ch("s11", 100, 1, 0, 1);
    check_val("s11_rdy", 32'(tgt_rdy), 0);
    wait_strobe(); check_val("s12_rdy", 32'(tgt_rdy), 0);
    capture(100, 48);
    wait_strobe(); check_val("s13_rdy", 32'(tgt_rdy), 0);
    check_val("s13_rduty", 32'(rght_duty), 0);
    wait_strobe(); check_val("s14_rdy", 32'(tgt_rdy), 0);
    check_val("s14_rfwd", 32'(rght_fwd), 1);
    wait_strobe(); expect_ch("s15", 100, 1, 0, 0);
    check_val("s15_rdy", 32'(tgt_rdy), 1);
    wait_strobe(); expect_ch("s16", 100, 1, 16, 0);
    wait_strobe(); expect_ch("s17", 100, 1, 32, 0);
    wait_strobe(); expect_ch("s18", 100, 1, 48, 0);
    check_val("s18_settled", 32'(settled), 1);

    // Async reset mid-ramp.
    capture(500, -48);
    wait_strobe(); expect_ch("s19", 116, 1, 48, 0);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    expect_ch("arst", 0, 1, 0, 1);
    check_val("arst_settled", 32'(settled), 1);
    check_val("arst_rdy", 32'(tgt_rdy), 1);
    check_val("arst_strb", 32'(period_strb), 0);

    // Release with -20 / -2048 offered; first strobe must land on clock 2047.
    @(negedge clk);
    tgt_vld = 1'b1; tgt_lft = 12'(-20); tgt_rght = 12'(-2048);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      tgt_vld = 1'b0;
    end while (!period_strb && n < 2100);
    check_val("first_strb_clk", n, 2047);

    wait_strobe(); expect_ch("c1", 16, 0, 16, 0);
    check_val("c1_rdy", 32'(tgt_rdy), 1);

    // Capture in the strobe cycle only takes effect at the following strobe.
    wait_strobe_high();
    tgt_vld = 1'b1; tgt_lft = 12'(64); tgt_rght = 12'(-2048);
    @(negedge clk);
    tgt_vld = 1'b0;
    expect_ch("c2", 20, 0, 32, 0);
    wait_strobe(); expect_ch("c3", 20, 0, 48, 0);

    // Reversal aborted during DECEL: no HOLD, direction kept.
    capture(-64, -2048);
    wait_strobe(); expect_ch("c4", 36, 0, 64, 0);
    check_val("c4_rdy", 32'(tgt_rdy), 1);
    wait_strobe(); expect_ch("c5", 52, 0, 80, 0);
    wait_strobe(); expect_ch("c6", 64, 0, 96, 0);
    check_val("c6_settled", 32'(settled), 0);

    // Zero target ramps down without flipping direction.
    capture(0, -2048);
    wait_strobe(); expect_ch("c7", 48, 0, 112, 0);
    check_val("c7_rdy", 32'(tgt_rdy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
